cpu_trace_buffer: RTL and testbench

Synthesizable instruction-retire trace recorder for the multicycle CPU54 core. It sits beside the CPU top and captures one entry per retired instruction into an on-chip buffer of parametrised depth: PC, instruction word, and the register-file write (enable, address, data). It supports streaming, circular and PC-triggered capture modes, and drains the buffer oldest-first over a valid/ready port. This replaces simulation-only `$fdisplay` register dumps with a trace that also works on hardware.

---
 rtl/cpu_trace_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: instruction-retire trace recorder for the CPU54 core.
// Captures {pc, inst, rf_we, rf_addr, rf_wdata} per retired instruction into
// a DEPTH-entry buffer with stream, circular and PC-triggered capture modes,
// and drains it oldest-first over a show-ahead valid/ready port.
// Optional build macro: TRACE_DUP_FILTER_EN suppresses an event whose pc/inst
// repeat the last accepted event, so ev_valid may be held as a level.
module cpu_trace_buffer #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          mode,
  input  logic                                arm,
  input  logic                                stop,
  input  logic [PC_W-1:0]                     trig_pc,
  input  logic [$clog2(DEPTH):0]              post_trig,
  input  logic                                ev_valid,
  input  logic [PC_W-1:0]                     ev_pc,
  input  logic [INST_W-1:0]                   ev_inst,
  input  logic                                ev_rf_we,
  input  logic [4:0]                          ev_rf_addr,
  input  logic [DATA_W-1:0]                   ev_rf_wdata,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [PC_W+INST_W+6+DATA_W-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]              count,
  output logic [1:0]                          state,
  output logic                                triggered,
  output logic [CNT_W-1:0]                    dropped
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned ENTRY_W = PC_W + INST_W + 6 + DATA_W;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_CAPTURE = 2'b01;
  localparam logic [1:0] ST_POST    = 2'b10;
  localparam logic [1:0] ST_FROZEN  = 2'b11;

  localparam logic [1:0] MODE_CIRC = 2'b01;
  localparam logic [1:0] MODE_TRIG = 2'b10;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] POST_MAX = CW'(DEPTH - 1);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_remain;
  logic [CW-1:0]      r_post;
  logic [1:0]         r_state;
  logic [1:0]         r_mode;
  logic [PC_W-1:0]    r_trig_pc;
  logic               r_triggered;
  logic [CNT_W-1:0]   r_dropped;

  logic [1:0]         w_state_nxt;
  logic               w_capturing;
  logic               w_stream;
  logic               w_full;
  logic               w_dup;
  logic               w_accept;
  logic               w_wr;
  logic               w_drop;
  logic               w_ovr;
  logic               w_pop;
  logic               w_trig_hit;
  logic               w_post_done;
  logic [CW-1:0]      w_post_sat;

  // Event qualification; fullness is judged before any same-cycle pop
  assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_stream    = (r_mode != MODE_CIRC) && (r_mode != MODE_TRIG);
  assign w_full      = (r_count == FULL_CNT);
  assign w_accept    = ev_valid && w_capturing && !arm && !w_dup;
  assign w_wr        = w_accept && !(w_stream && w_full);
  assign w_drop      = w_accept && w_stream && w_full;
  assign w_ovr       = w_wr && !w_stream && w_full;
  assign w_trig_hit  = w_wr && (r_state == ST_CAPTURE) && (r_mode == MODE_TRIG) &&
                       (ev_pc == r_trig_pc);
  assign w_post_done = w_wr && (r_state == ST_POST) && (r_remain == CW'(1));
  assign w_post_sat  = (post_trig > POST_MAX) ? POST_MAX : post_trig;

  // Circular/trigger modes hide the buffer until capture has stopped
  assign rd_valid = (r_count != '0) && (w_stream || !w_capturing);
  assign w_pop    = rd_valid && rd_ready && !arm;
  assign rd_data  = r_mem[r_rd_ptr];

  assign count     = r_count;
  assign state     = r_state;
  assign triggered = r_triggered;
  assign dropped   = r_dropped;

`ifdef TRACE_DUP_FILTER_EN
  logic              r_hist_vld;
  logic [PC_W-1:0]   r_last_pc;
  logic [INST_W-1:0] r_last_inst;

  assign w_dup = r_hist_vld && (ev_pc == r_last_pc) && (ev_inst == r_last_inst);

  // History of the last accepted event; cleared so the first event after arm passes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist_vld  <= 1'b0;
      r_last_pc   <= '0;
      r_last_inst <= '0;
    end else if (arm) begin
      r_hist_vld  <= 1'b0;
    end else if (w_accept) begin
      r_hist_vld  <= 1'b1;
      r_last_pc   <= ev_pc;
      r_last_inst <= ev_inst;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // Next-state logic: arm beats stop, stop beats trigger progress
  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = ST_CAPTURE;
    end else if (stop && w_capturing) begin
      w_state_nxt = ST_FROZEN;
    end else if (w_trig_hit) begin
      w_state_nxt = (r_post == '0) ? ST_FROZEN : ST_POST;
    end else if (w_post_done) begin
      w_state_nxt = ST_FROZEN;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointers, occupancy, drop counter and trigger bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dropped   <= '0;
      r_triggered <= 1'b0;
      r_remain    <= '0;
      r_post      <= '0;
      r_mode      <= '0;
      r_trig_pc   <= '0;
    end else if (arm) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dropped   <= '0;
      r_triggered <= 1'b0;
      r_remain    <= '0;
      r_post      <= w_post_sat;
      r_mode      <= mode;
      r_trig_pc   <= trig_pc;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop || w_ovr) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr && !w_ovr && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop && (r_dropped != '1)) begin
        r_dropped <= r_dropped + CNT_W'(1);
      end
      if (w_trig_hit) begin
        r_triggered <= 1'b1;
        r_remain    <= r_post;
      end else if (w_wr && (r_state == ST_POST)) begin
        r_remain    <= r_remain - CW'(1);
      end
    end
  end

  // Trace storage; contents are never cleared, only the pointers
  always_ff @(posedge clk) begin
    if (w_wr && rst_n) begin
      r_mem[r_wr_ptr] <= {ev_pc, ev_inst, ev_rf_we, ev_rf_addr, ev_rf_wdata};
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Testbench for cpu_trace_buffer (DEPTH=8): directed stimulus pushes expected
// drain entries into a scoreboard queue; a monitor pops and compares on each pop.
module tb_cpu_trace_buffer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned ENTRY_W = 102;

  logic               clk;
  logic               rst_n;
  logic [1:0]         mode;
  logic               arm;
  logic               stop;
  logic [31:0]        trig_pc;
  logic [AW:0]        post_trig;
  logic               ev_valid;
  logic [31:0]        ev_pc;
  logic [31:0]        ev_inst;
  logic               ev_rf_we;
  logic [4:0]         ev_rf_addr;
  logic [31:0]        ev_rf_wdata;
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;
  logic [AW:0]        count;
  logic [1:0]         state;
  logic               triggered;
  logic [15:0]        dropped;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ENTRY_W-1:0] sb_q[$];

  cpu_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .arm(arm), .stop(stop),
    .trig_pc(trig_pc), .post_trig(post_trig), .ev_valid(ev_valid),
    .ev_pc(ev_pc), .ev_inst(ev_inst), .ev_rf_we(ev_rf_we),
    .ev_rf_addr(ev_rf_addr), .ev_rf_wdata(ev_rf_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .state(state), .triggered(triggered), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [ENTRY_W-1:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic we, input logic [4:0] a,
                                            input logic [31:0] d);
    return {pc, inst, we, a, d};
  endfunction

  function automatic logic [31:0] lin_pc(input int k);
    return 32'h0040_0000 + 32'(4 * k);
  endfunction

  function automatic logic [31:0] lin_inst(input int k);
    return 32'h0010_0093 + 32'(k);
  endfunction

  function automatic logic [ENTRY_W-1:0] lin_entry(input int k);
    return mk(lin_pc(k), lin_inst(k), 1'b0, 5'd0, 32'd0);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got %0h expected no entry", rd_data);
      end else begin
        check("sb_entry", 128'(rd_data), 128'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                      input logic [4:0] a, input logic [31:0] d);
    ev_valid = 1'b1; ev_pc = pc; ev_inst = inst;
    ev_rf_we = we; ev_rf_addr = a; ev_rf_wdata = d;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic send_lin(input int k);
    send(lin_pc(k), lin_inst(k), 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [31:0] tpc, input logic [AW:0] pt,
                        input logic with_ev);
    arm = 1'b1; mode = m; trig_pc = tpc; post_trig = pt;
    ev_valid = with_ev; ev_pc = lin_pc(99); ev_inst = lin_inst(99);
    tick();
    arm = 1'b0; ev_valid = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    rd_ready = 1'b0;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; arm = 1'b0; stop = 1'b0; trig_pc = '0; post_trig = '0;
    ev_valid = 1'b0; ev_pc = '0; ev_inst = '0; ev_rf_we = 1'b0; ev_rf_addr = '0;
    ev_rf_wdata = '0; rd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_state", 128'(state), 128'(2'b00));
    check("rst_triggered", 128'(triggered), 128'(0));
    check("rst_dropped", 128'(dropped), 128'(0));

    // Stream: 10 events into 8 entries, last two dropped
    do_arm(2'b00, 32'd0, '0, 1'b0);
    check("stream_state", 128'(state), 128'(2'b01));
    for (int k = 0; k < 10; k++) send_lin(k);
    check("stream_count", 128'(count), 128'(8));
    check("stream_dropped", 128'(dropped), 128'(2));
    for (int k = 0; k < 8; k++) sb_q.push_back(lin_entry(k));
    drain();
    check("stream_empty_valid", 128'(rd_valid), 128'(0));
    check("stream_empty_count", 128'(count), 128'(0));

    // Stream: concurrent write and pop keep count steady
    sb_q.push_back(lin_entry(20));
    sb_q.push_back(lin_entry(21));
    send_lin(20);
    check("wp_count_before", 128'(count), 128'(1));
    rd_ready = 1'b1;
    send_lin(21);
    check("wp_count_steady", 128'(count), 128'(1));
    tick();
    rd_ready = 1'b0;
    check("wp_count_after", 128'(count), 128'(0));

    // arm together with ev_valid discards the event
    send_lin(30);
    check("pre_arm_count", 128'(count), 128'(1));
    do_arm(2'b00, 32'd0, '0, 1'b1);
    check("arm_ev_count", 128'(count), 128'(0));
    check("arm_ev_valid", 128'(rd_valid), 128'(0));

    // Circular: 12 events overwrite oldest; hidden until stop
    do_arm(2'b01, 32'd0, '0, 1'b0);
    rd_ready = 1'b1;
    for (int k = 0; k < 12; k++) send_lin(k);
    check("circ_hidden_valid", 128'(rd_valid), 128'(0));
    check("circ_dropped", 128'(dropped), 128'(0));
    rd_ready = 1'b0;
    for (int k = 4; k < 12; k++) sb_q.push_back(lin_entry(k));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("circ_frozen", 128'(state), 128'(2'b11));
    check("circ_count", 128'(count), 128'(8));
    drain();

    // Trigger at 0x00400040 with 3 post-trigger entries
    do_arm(2'b10, 32'h0040_0040, 4'd3, 1'b0);
    for (int k = 0; k < 19; k++) send_lin(k);
    check("trig_post_state", 128'(state), 128'(2'b10));
    send_lin(19);
    check("trig_frozen", 128'(state), 128'(2'b11));
    check("trig_flag", 128'(triggered), 128'(1));
    send_lin(20);
    send_lin(21);
    check("trig_count", 128'(count), 128'(8));
    for (int k = 12; k < 20; k++) sb_q.push_back(lin_entry(k));
    drain();

    // Trigger with post_trig = 0 freezes right after the trigger entry
    do_arm(2'b10, 32'h0040_0040, 4'd0, 1'b0);
    for (int k = 0; k < 16; k++) send_lin(k);
    check("trig0_capture", 128'(state), 128'(2'b01));
    check("trig0_not_yet", 128'(triggered), 128'(0));
    send_lin(16);
    check("trig0_frozen", 128'(state), 128'(2'b11));
    check("trig0_flag", 128'(triggered), 128'(1));

    // Reset while in POST
    do_arm(2'b10, 32'h0040_0040, 4'd3, 1'b0);
    for (int k = 0; k < 17; k++) send_lin(k);
    check("rpost_in_post", 128'(state), 128'(2'b10));
    rst_n = 1'b0;
    tick();
    check("rpost_state", 128'(state), 128'(2'b00));
    check("rpost_count", 128'(count), 128'(0));
    check("rpost_valid", 128'(rd_valid), 128'(0));
    check("rpost_triggered", 128'(triggered), 128'(0));
    check("rpost_dropped", 128'(dropped), 128'(0));
    rst_n = 1'b1;
    tick();

    // Level-held retire strobe on one instruction, then a new PC
    do_arm(2'b00, 32'd0, '0, 1'b0);
    for (int i = 0; i < 4; i++) send(32'h0040_0200, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
    send(32'h0040_0204, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
`ifdef TRACE_DUP_FILTER_EN
    check("dup_count", 128'(count), 128'(2));
`else
    check("dup_count", 128'(count), 128'(5));
`endif

    // Register-write payload
    do_arm(2'b00, 32'd0, '0, 1'b0);
    send(32'h0040_0100, 32'h1234_5678, 1'b1, 5'd8, 32'hDEAD_BEEF);
    check("payload_valid", 128'(rd_valid), 128'(1));
    check("payload_low", 128'(rd_data[37:0]), 128'({1'b1, 5'd8, 32'hDEAD_BEEF}));
    sb_q.push_back(mk(32'h0040_0100, 32'h1234_5678, 1'b1, 5'd8, 32'hDEAD_BEEF));
    drain();
    check("final_empty", 128'(rd_valid), 128'(0));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
